// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - IF/MEM client and byte-wide RAM port bundle for mem_ctrl
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              if_enable_in;
  logic [ADDR_W-1:0] if_addr_in;
  logic              inst_done_out;
  logic [31:0]       inst_out;
  logic              inst_busy_out;
  logic              mem_enable_in;
  logic              mem_rw_in;
  logic [2:0]        mem_width_in;
  logic [ADDR_W-1:0] mem_addr_in;
  logic [31:0]       mem_wdata_in;
  logic              mem_done_out;
  logic [31:0]       mem_rdata_out;
  logic              mem_busy_out;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;

  modport master (
    output if_enable_in, if_addr_in, mem_enable_in, mem_rw_in, mem_width_in,
           mem_addr_in, mem_wdata_in, ram_din,
    input  inst_done_out, inst_out, inst_busy_out, mem_done_out, mem_rdata_out,
           mem_busy_out, ram_dout, ram_a, ram_wr
  );

  modport slave (
    input  if_enable_in, if_addr_in, mem_enable_in, mem_rw_in, mem_width_in,
           mem_addr_in, mem_wdata_in, ram_din,
    output inst_done_out, inst_out, inst_busy_out, mem_done_out, mem_rdata_out,
           mem_busy_out, ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM controller serving IF fetches and MEM loads/stores
// MC_MEM_PRIORITY_EN: MEM wins simultaneous requests; undefined gives round-robin arbitration.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        n_q, n_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       inst_q, inst_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              pick_mem;
  logic [1:0]        rd_idx;
  logic [ADDR_W-1:0] beat_addr;
  logic [ADDR_W-1:0] ram_a_c;
  logic [7:0]        ram_dout_c;
  logic              ram_wr_c;
`ifndef MC_MEM_PRIORITY_EN
  logic              last_q, last_d;
`endif

  // ram_din in the cycle with cnt=c belongs to the address issued at c-1
  assign rd_idx    = cnt_q[1:0] - 2'd1;
  assign beat_addr = base_q + ADDR_W'(cnt_q);

  always_comb begin
`ifdef MC_MEM_PRIORITY_EN
    pick_mem = bus.mem_enable_in;
`else
    pick_mem = bus.mem_enable_in && (!bus.if_enable_in || last_q == OWN_IF);
`endif
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    base_d     = base_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    wdata_d    = wdata_q;
    inst_d     = inst_q;
    rdata_d    = rdata_q;
    ram_a_c    = '0;
    ram_dout_c = '0;
    ram_wr_c   = 1'b0;
`ifndef MC_MEM_PRIORITY_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_mem || bus.if_enable_in) begin
          owner_d = pick_mem ? OWN_MEM : OWN_IF;
          base_d  = pick_mem ? bus.mem_addr_in : bus.if_addr_in;
          n_d     = !pick_mem ? 3'd4 :
                    bus.mem_width_in[2] ? 3'd4 : (bus.mem_width_in[1] ? 3'd2 : 3'd1);
          wdata_d = pick_mem ? bus.mem_wdata_in : 32'h0;
          state_d = (pick_mem && bus.mem_rw_in) ? WRITE : READ;
          cnt_d   = 3'd0;
          buf_d   = 32'h0;
`ifndef MC_MEM_PRIORITY_EN
          last_d  = pick_mem ? OWN_MEM : OWN_IF;
`endif
        end
      end
      READ: begin
        if (cnt_q < n_q) ram_a_c = beat_addr;
        if (cnt_q != 3'd0) buf_d[{rd_idx, 3'b000} +: 8] = bus.ram_din;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == n_q) begin
          state_d = DONE;
          if (owner_q == OWN_IF) inst_d = buf_d;
          else                   rdata_d = buf_d;
        end
      end
      WRITE: begin
        ram_wr_c   = 1'b1;
        ram_a_c    = beat_addr;
        ram_dout_c = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        cnt_d      = cnt_q + 3'd1;
        if (cnt_q == n_q - 3'd1) begin
          state_d = DONE;
          rdata_d = 32'h0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      base_q  <= '0;
      n_q     <= 3'd0;
      cnt_q   <= 3'd0;
      buf_q   <= 32'h0;
      wdata_q <= 32'h0;
      inst_q  <= 32'h0;
      rdata_q <= 32'h0;
`ifndef MC_MEM_PRIORITY_EN
      last_q  <= OWN_IF;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      wdata_q <= wdata_d;
      inst_q  <= inst_d;
      rdata_q <= rdata_d;
`ifndef MC_MEM_PRIORITY_EN
      last_q  <= last_d;
`endif
    end
  end

  assign bus.inst_done_out = (state_q == DONE) && (owner_q == OWN_IF);
  assign bus.mem_done_out  = (state_q == DONE) && (owner_q == OWN_MEM);
  assign bus.inst_busy_out = (state_q != IDLE);
  assign bus.mem_busy_out  = (state_q != IDLE);
  assign bus.inst_out      = inst_q;
  assign bus.mem_rdata_out = rdata_q;
  assign bus.ram_a         = ram_a_c;
  assign bus.ram_dout      = ram_dout_c;
  assign bus.ram_wr        = ram_wr_c;
endmodule
